// File: rtl/out_signature.sv
// out_signature: compresses the scan-inject core's 1-bit output into a 16-bit
// MISR signature plus a ones count over a fixed window, handed off via valid/ready.
module out_signature #(
    parameter int          WINDOW = 64,
    parameter logic [15:0] SEED   = 16'hACE1,
    localparam int         CW     = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          din,
    output logic          busy,
    output logic          valid,
    input  logic          ready,
    output logic [15:0]   sig,
    output logic [CW-1:0] ones
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter value seen on the cycle that takes the final sample.
    localparam logic [15:0] LAST_CNT = 16'(WINDOW - 1);

    state_t        state_r;
    state_t        state_s;
    logic [15:0]   sig_r;
    logic [15:0]   sig_s;
    logic [15:0]   cnt_r;
    logic [15:0]   cnt_s;
    logic [CW-1:0] ones_r;
    logic [CW-1:0] ones_s;
    logic          busy_r;
    logic          valid_r;

    function automatic logic misr_fb(input logic [15:0] s);
        return s[15] ^ s[13] ^ s[12] ^ s[10];
    endfunction

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_s = state_r;
        sig_s   = sig_r;
        ones_s  = ones_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    sig_s   = SEED;
                    ones_s  = {CW{1'b0}};
                    cnt_s   = 16'h0000;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                sig_s  = {sig_r[14:0], misr_fb(sig_r) ^ din};
                ones_s = ones_r + CW'(din);
                cnt_s  = cnt_r + 16'd1;
                if (cnt_r == LAST_CNT) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and result registers; busy/valid are registered from the next state
    // so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sig_r   <= 16'h0000;
            ones_r  <= {CW{1'b0}};
            cnt_r   <= 16'h0000;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            sig_r   <= sig_s;
            ones_r  <= ones_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == RUN);
            valid_r <= (state_s == DONE);
        end
    end

    assign busy  = busy_r;
    assign valid = valid_r;
    assign sig   = sig_r;
    assign ones  = ones_r;

endmodule

// File: tb/tb_out_signature.sv
// Directed self-checking bench for out_signature: a WINDOW=2 instance with
// hand-computed signatures and a WINDOW=64 instance checked against a MISR model.
module tb_out_signature;

    logic        clk;
    logic        rst;
    logic        start;
    logic        din;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [15:0] sig;
    logic [6:0]  ones;

    logic        start2;
    logic        din2;
    logic        ready2;
    logic        busy2;
    logic        valid2;
    logic [15:0] sig2;
    logic [1:0]  ones2;

    int checks;
    int errors;

    out_signature #(.WINDOW(64), .SEED(16'hACE1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .busy(busy),
        .valid(valid), .ready(ready), .sig(sig), .ones(ones)
    );

    out_signature #(.WINDOW(2), .SEED(16'hACE1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .din(din2), .busy(busy2),
        .valid(valid2), .ready(ready2), .sig(sig2), .ones(ones2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] misr(input logic [15:0] s, input logic d);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full 64-sample measurement, starting in the current cycle, ending at H+1.
    task automatic run64(input string tag, input logic [63:0] pat, input bit disturb);
        logic [15:0] exp_sig;
        int          exp_ones;
        exp_sig  = 16'hACE1;
        exp_ones = 0;
        start = 1'b1;
        din   = ~pat[0];
        ready = disturb;
        tick();
        start = 1'b0;
        chk({tag, "/busy_first"}, 32'(busy), 32'd1);
        chk({tag, "/sig_seed"}, 32'(sig), 32'hACE1);
        for (int i = 0; i < 64; i++) begin
            din   = pat[i];
            start = disturb && ((i % 16) == 5);
            ready = disturb;
            exp_sig  = misr(exp_sig, pat[i]);
            exp_ones = exp_ones + int'(pat[i]);
            if (i == 63) begin
                chk({tag, "/valid_early"}, 32'(valid), 32'd0);
                chk({tag, "/busy_last"}, 32'(busy), 32'd1);
            end
            tick();
        end
        start = 1'b0;
        ready = 1'b0;
        chk({tag, "/valid"}, 32'(valid), 32'd1);
        chk({tag, "/busy_done"}, 32'(busy), 32'd0);
        chk({tag, "/sig"}, 32'(sig), 32'(exp_sig));
        chk({tag, "/ones"}, 32'(ones), 32'(exp_ones));
        for (int k = 0; k < 3; k++) begin
            start = disturb;
            din   = k[0];
            tick();
            chk({tag, "/valid_hold"}, 32'(valid), 32'd1);
            chk({tag, "/sig_hold"}, 32'(sig), 32'(exp_sig));
            chk({tag, "/ones_hold"}, 32'(ones), 32'(exp_ones));
        end
        ready = 1'b1;
        start = disturb;
        tick();
        chk({tag, "/valid_off"}, 32'(valid), 32'd0);
        chk({tag, "/busy_off"}, 32'(busy), 32'd0);
        ready = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_sig;
        logic [63:0] pat;
        checks = 0;
        errors = 0;
        pat    = 64'hDEAD_BEEF_0123_4567;

        // Reset held two cycles with start and din asserted.
        rst = 1'b1; start = 1'b1; din = 1'b1; ready = 1'b0;
        start2 = 1'b1; din2 = 1'b1; ready2 = 1'b0;
        tick();
        tick();
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/valid", 32'(valid), 32'd0);
        chk("rst/sig", 32'(sig), 32'h0);
        chk("rst/ones", 32'(ones), 32'd0);
        chk("rst/busy2", 32'(busy2), 32'd0);
        chk("rst/sig2", 32'(sig2), 32'h0);
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = i[0];
            tick();
            chk("idle/busy", 32'(busy), 32'd0);
            chk("idle/valid", 32'(valid), 32'd0);
            chk("idle/sig", 32'(sig), 32'h0);
        end

        // WINDOW=2, din=0, ready=1: hand-computed signatures.
        ready2 = 1'b1; din2 = 1'b0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("w2/busy_t1", 32'(busy2), 32'd1);
        chk("w2/sig_seed", 32'(sig2), 32'hACE1);
        tick();
        chk("w2/sig_1", 32'(sig2), 32'h59C3);
        chk("w2/valid_t2", 32'(valid2), 32'd0);
        tick();
        chk("w2/valid_t3", 32'(valid2), 32'd1);
        chk("w2/sig_res", 32'(sig2), 32'hB387);
        chk("w2/ones_res", 32'(ones2), 32'd0);
        chk("w2/busy_t3", 32'(busy2), 32'd0);
        tick();
        chk("w2/valid_t4", 32'(valid2), 32'd0);
        chk("w2/sig_kept", 32'(sig2), 32'hB387);

        // Back-to-back start at H+1 with the same stream.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("b2b/busy", 32'(busy2), 32'd1);
        tick();
        chk("b2b/valid_t2", 32'(valid2), 32'd0);
        tick();
        chk("b2b/valid_t3", 32'(valid2), 32'd1);
        chk("b2b/sig", 32'(sig2), 32'hB387);
        chk("b2b/ones", 32'(ones2), 32'd0);

        // WINDOW=2 with din=1: ones reaches WINDOW.
        tick();
        din2 = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        tick();
        chk("w2d1/valid", 32'(valid2), 32'd1);
        chk("w2d1/sig", 32'(sig2), 32'hB384);
        chk("w2d1/ones", 32'(ones2), 32'd2);
        ready2 = 1'b0;

        // WINDOW=64, din=1, consumer stalls 10 cycles.
        exp_sig = 16'hACE1;
        for (int i = 0; i < 64; i++) exp_sig = misr(exp_sig, 1'b1);
        din = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        chk("w64/busy_last", 32'(busy), 32'd1);
        chk("w64/valid_early", 32'(valid), 32'd0);
        tick();
        chk("w64/valid", 32'(valid), 32'd1);
        chk("w64/ones", 32'(ones), 32'd64);
        chk("w64/sig", 32'(sig), 32'(exp_sig));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("w64/stall_valid", 32'(valid), 32'd1);
            chk("w64/stall_sig", 32'(sig), 32'(exp_sig));
            chk("w64/stall_ones", 32'(ones), 32'd64);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("w64/idle_valid", 32'(valid), 32'd0);
        chk("w64/idle_busy", 32'(busy), 32'd0);

        // Clean run, then a disturbed run with start/ready/din noise.
        run64("clean", pat, 1'b0);
        run64("gated", pat, 1'b1);
        tick();
        chk("gated/no_queue", 32'(busy), 32'd0);

        // Reset after 30 samples discards the measurement.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            din = pat[i];
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst/busy", 32'(busy), 32'd0);
        chk("mid_rst/valid", 32'(valid), 32'd0);
        chk("mid_rst/sig", 32'(sig), 32'h0);
        chk("mid_rst/ones", 32'(ones), 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("mid_rst/no_valid", 32'(valid), 32'd0);
        end
        run64("after_rst", pat, 1'b0);
        run64("b2b64", ~pat, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
